// File: rtl/sprite_anim_src.sv
// Sprite pixel source: FRAMES animation frames of H_SIZE x V_SIZE pixels held
// in a simple dual-port RAM, with 1x/2x scaling, mirroring and frame stepping.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   x, y, x0, y0        scan position and sprite top-left origin
//   frame_tick          one-cycle pulse at the start of each video frame
//   we, addr_w, pixel_in  sprite RAM write port; address is {frame, row, col}
//   en, flip_h, flip_v, scale2x  draw controls, sampled with x/y
//   anim_en, frame_sel, anim_period  frame selection and animation rate
//   sprite_rgb, sprite_on  chroma-keyed pixel, two cycles after x/y
module sprite_anim_src #(
    parameter int CD = 12,
    parameter int H_SIZE = 32,
    parameter int V_SIZE = 32,
    parameter int FRAMES = 4,
    parameter int ADDR = 12,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [10:0]     x,
    input  logic [10:0]     y,
    input  logic [10:0]     x0,
    input  logic [10:0]     y0,
    input  logic            frame_tick,
    input  logic            we,
    input  logic [ADDR-1:0] addr_w,
    input  logic [CD-1:0]   pixel_in,
    input  logic            en,
    input  logic            flip_h,
    input  logic            flip_v,
    input  logic            scale2x,
    input  logic            anim_en,
    input  logic [2:0]      frame_sel,
    input  logic [7:0]      anim_period,
    output logic [CD-1:0]   sprite_rgb,
    output logic            sprite_on
);

    localparam int CW = $clog2(H_SIZE);
    localparam int RW = $clog2(V_SIZE);
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int AW = FW + RW + CW;

    logic [CD-1:0]   mem_q [0:(1<<ADDR)-1];
    logic [CD-1:0]   dout_q;

    logic [FW-1:0]   cur_frame_q, cur_frame_d;
    logic [7:0]      tick_cnt_q, tick_cnt_d;
    logic            in_d1_q, in_d1_d;
    logic [CD-1:0]   rgb_q, rgb_d;
    logic            on_q, on_d;

    logic [11:0]     xr, yr;
    logic [11:0]     w_lim, h_lim;
    logic            in_region;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [AW-1:0]   rd_full;
    logic [ADDR-1:0] rd_addr;
    logic [7:0]      period;

    // Stage 0: relative position, region test and RAM address.
    // Bit 11 of the zero-extended difference is the sign of xr/yr.
    always_comb begin
        xr = {1'b0, x} - {1'b0, x0};
        yr = {1'b0, y} - {1'b0, y0};
        w_lim = scale2x ? 12'(2 * H_SIZE) : 12'(H_SIZE);
        h_lim = scale2x ? 12'(2 * V_SIZE) : 12'(V_SIZE);
        in_region = en && !xr[11] && (xr < w_lim)
                       && !yr[11] && (yr < h_lim);
        col = scale2x ? xr[CW:1] : xr[CW-1:0];
        row = scale2x ? yr[RW:1] : yr[RW-1:0];
        // Size is a power of two, so size-1-idx is the bitwise inverse.
        if (flip_h) col = ~col;
        if (flip_v) row = ~row;
        rd_full = {cur_frame_q, row, col};
        // With a single frame the frame field drops out of the address.
        rd_addr = rd_full[ADDR-1:0];
    end

    // Frame selection only changes on frame_tick to avoid tearing.
    always_comb begin
        cur_frame_d = cur_frame_q;
        tick_cnt_d = tick_cnt_q;
        period = (anim_period == 8'd0) ? 8'd1 : anim_period;
        if (frame_tick) begin
            if (!anim_en) begin
                cur_frame_d = frame_sel[FW-1:0];
                tick_cnt_d = '0;
            end else if ({1'b0, tick_cnt_q} + 9'd1 >= {1'b0, period}) begin
                tick_cnt_d = '0;
                cur_frame_d = cur_frame_q + 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 8'd1;
            end
        end
        if (FRAMES == 1) cur_frame_d = '0;
    end

    // Stage 2: chroma key against the registered RAM word.
    always_comb begin
        in_d1_d = in_region;
        on_d = in_d1_q && (dout_q != KEY_COLOR);
        rgb_d = on_d ? dout_q : KEY_COLOR;
    end

    // Read-first RAM: the read register sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) mem_q[addr_w] <= pixel_in;
        dout_q <= mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_frame_q <= '0;
            tick_cnt_q <= '0;
            in_d1_q <= 1'b0;
            rgb_q <= KEY_COLOR;
            on_q <= 1'b0;
        end else begin
            cur_frame_q <= cur_frame_d;
            tick_cnt_q <= tick_cnt_d;
            in_d1_q <= in_d1_d;
            rgb_q <= rgb_d;
            on_q <= on_d;
        end
    end

    assign sprite_rgb = rgb_q;
    assign sprite_on = on_q;

endmodule

// File: tb/tb_sprite_anim_src.sv
// Scoreboard bench for sprite_anim_src: a driver computes expected pixels
// from a behavioural model and queues them; a monitor checks DUT output.
module tb_sprite_anim_src;

    localparam int CD = 12;
    localparam int HS = 32;
    localparam int VS = 32;
    localparam int NF = 4;
    localparam int AD = 12;
    localparam logic [CD-1:0] KEY = '0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   x = '0, y = '0, x0 = '0, y0 = '0;
    logic          frame_tick = 1'b0;
    logic          we = 1'b0;
    logic [AD-1:0] addr_w = '0;
    logic [CD-1:0] pixel_in = '0;
    logic          en = 1'b0, flip_h = 1'b0, flip_v = 1'b0, scale2x = 1'b0;
    logic          anim_en = 1'b0;
    logic [2:0]    frame_sel = '0;
    logic [7:0]    anim_period = '0;
    logic [CD-1:0] sprite_rgb;
    logic          sprite_on;

    always #5 clk = ~clk;

    sprite_anim_src #(
        .CD(CD), .H_SIZE(HS), .V_SIZE(VS), .FRAMES(NF), .ADDR(AD),
        .KEY_COLOR(KEY)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .x(x), .y(y), .x0(x0), .y0(y0),
        .frame_tick(frame_tick),
        .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
        .en(en), .flip_h(flip_h), .flip_v(flip_v), .scale2x(scale2x),
        .anim_en(anim_en), .frame_sel(frame_sel), .anim_period(anim_period),
        .sprite_rgb(sprite_rgb), .sprite_on(sprite_on)
    );

    typedef struct {
        int            due;
        logic [CD-1:0] rgb;
        logic          on;
    } exp_t;

    exp_t sbq[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Behavioural model state.
    int mem_m [0:(1<<AD)-1];
    int cur_m = 0;
    int cnt_m = 0;

    // Monitor: one output per cycle, matched by due cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL missed due=%0d now=%0d", e.due, cyc);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checks++;
                if (sprite_rgb !== e.rgb || sprite_on !== e.on) begin
                    failures++;
                    $display("FAIL pixel cyc=%0d got rgb=%h on=%b want rgb=%h on=%b",
                             cyc, sprite_rgb, sprite_on, e.rgb, e.on);
                end
            end
        end
    end

    // Apply the current inputs for one cycle and queue the expected output.
    task automatic drive();
        exp_t e;
        int xr, yr, sc, col, row, pix, p;
        bit in_r;
        if (!reset_n) begin
            while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
            e.rgb = KEY;
            e.on = 1'b0;
            e.due = cyc + 1;
            sbq.push_back(e);
            e.due = cyc + 2;
            sbq.push_back(e);
            cur_m = 0;
            cnt_m = 0;
        end else begin
            xr = int'(x) - int'(x0);
            yr = int'(y) - int'(y0);
            sc = scale2x ? 2 : 1;
            in_r = en && xr >= 0 && xr < HS * sc && yr >= 0 && yr < VS * sc;
            pix = int'(KEY);
            if (in_r) begin
                col = xr / sc;
                row = yr / sc;
                if (flip_h) col = HS - 1 - col;
                if (flip_v) row = VS - 1 - row;
                pix = mem_m[cur_m * HS * VS + row * HS + col];
            end
            e.due = cyc + 2;
            e.on = in_r && (pix != int'(KEY));
            e.rgb = e.on ? CD'(pix) : KEY;
            sbq.push_back(e);
            if (frame_tick) begin
                if (!anim_en) begin
                    cur_m = int'(frame_sel) % NF;
                    cnt_m = 0;
                end else begin
                    p = (anim_period == 0) ? 1 : int'(anim_period);
                    if (cnt_m + 1 >= p) begin
                        cnt_m = 0;
                        cur_m = (cur_m + 1) % NF;
                    end else begin
                        cnt_m++;
                    end
                end
            end
        end
        if (we) mem_m[addr_w] = int'(pixel_in);
        @(negedge clk);
    endtask

    task automatic px(input int xx, input int yy);
        x = 11'(xx);
        y = 11'(yy);
        drive();
    endtask

    task automatic wr(input int a, input int d);
        we = 1'b1;
        addr_w = AD'(a);
        pixel_in = CD'(d);
        drive();
        we = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        drive();
        frame_tick = 1'b0;
    endtask

    task automatic scan_row(input int xa, input int xb, input int yy);
        for (int i = xa; i <= xb; i++) px(i, yy);
    endtask

    initial begin
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) drive();
        reset_n = 1'b1;
        drive();

        // Frame 0 col-coded, frame 1 row-coded, frames 2/3 random.
        for (int a = 0; a < NF * HS * VS; a++) begin
            case (a / (HS * VS))
                0: wr(a, a % HS);
                1: wr(a, (a / HS) % VS);
                default: wr(a, int'($urandom_range(0, 4095)));
            endcase
        end

        x0 = 11'd100;
        y0 = 11'd50;
        en = 1'b1;
        scan_row(99, 132, 50);
        flip_h = 1'b1;
        scan_row(99, 132, 50);
        flip_h = 1'b0;

        // Row-coded frame with vertical mirror.
        frame_sel = 3'd1;
        tick();
        flip_v = 1'b1;
        scan_row(99, 132, 50);
        px(110, 81);
        flip_v = 1'b0;
        px(110, 81);
        px(110, 82);

        // 2x scaling at the origin.
        frame_sel = 3'd0;
        tick();
        x0 = 11'd0;
        y0 = 11'd0;
        scale2x = 1'b1;
        scan_row(0, 66, 63);
        scan_row(0, 4, 64);
        scale2x = 1'b0;

        // Solid frames for animation.
        en = 1'b0;
        for (int a = 0; a < NF * HS * VS; a++) wr(a, a / (HS * VS) + 1);
        en = 1'b1;
        x0 = 11'd200;
        y0 = 11'd100;
        anim_en = 1'b1;
        anim_period = 8'd2;
        for (int t = 0; t < 9; t++) begin
            tick();
            repeat (2) px(210, 110);
        end
        anim_period = 8'd0;
        for (int t = 0; t < 5; t++) begin
            tick();
            px(205, 105);
        end

        // Manual selection only takes effect at the next tick.
        anim_en = 1'b0;
        frame_sel = 3'd0;
        tick();
        repeat (2) px(220, 120);
        frame_sel = 3'd2;
        repeat (3) px(221, 121);
        tick();
        repeat (3) px(222, 122);

        // One-cycle reset during a visible pixel.
        repeat (2) px(215, 115);
        reset_n = 1'b0;
        px(215, 115);
        reset_n = 1'b1;
        repeat (4) px(215, 115);

        // Write and read the same address in one cycle.
        x0 = 11'd100;
        y0 = 11'd50;
        we = 1'b1;
        addr_w = AD'(5);
        pixel_in = 12'hABC;
        px(105, 50);
        we = 1'b0;
        px(105, 50);
        px(105, 50);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 7) != 0);
            flip_h = 1'($urandom);
            flip_v = 1'($urandom);
            scale2x = 1'($urandom);
            anim_en = 1'($urandom);
            frame_sel = 3'($urandom);
            anim_period = 8'($urandom_range(0, 3));
            frame_tick = ($urandom_range(0, 15) == 0);
            we = ($urandom_range(0, 3) == 0);
            addr_w = AD'($urandom);
            pixel_in = CD'($urandom);
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) begin
                x0 = 11'($urandom);
                y0 = 11'($urandom);
            end
            x = 11'(int'(x0) + int'($urandom_range(0, 80)) - 8);
            y = 11'(int'(y0) + int'($urandom_range(0, 80)) - 8);
            drive();
        end
        frame_tick = 1'b0;
        we = 1'b0;
        reset_n = 1'b1;
        en = 1'b0;
        repeat (3) drive();

        repeat (5) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
